// File: rtl/prim_esc_rxtx_monitor.sv
// Per-channel integrity filter, ping watchdog and escalation counter for differential escalation
// links. Define PRIM_ESC_MON_LOCK_EN to make the sticky failure flags lock until reset.
module prim_esc_rxtx_monitor #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned ERR_FILTER   = 2,
  parameter int unsigned PING_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CH-1:0]       esc_pi,
  input  logic [N_CH-1:0]       esc_ni,
  input  logic [N_CH-1:0]       resp_pi,
  input  logic [N_CH-1:0]       resp_ni,
  input  logic [N_CH-1:0]       ping_req_i,
  input  logic [N_CH-1:0]       clr_i,
  output logic [N_CH-1:0]       integ_fail_o,
  output logic [N_CH-1:0]       ping_ok_o,
  output logic [N_CH-1:0]       ping_timeout_o,
  output logic [N_CH-1:0]       esc_active_o,
  output logic [N_CH*CNT_W-1:0] esc_cnt_o,
  output logic                  any_fail_o
);

`ifdef PRIM_ESC_MON_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  localparam int unsigned FiltW = $clog2(ERR_FILTER + 1);
  localparam int unsigned TmrW  = $clog2(PING_TIMEOUT);

  localparam logic [FiltW-1:0] FiltMax = FiltW'(ERR_FILTER);
  localparam logic [TmrW-1:0]  TmrMax  = TmrW'(PING_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StWait, StTout} ping_st_e;

  logic [N_CH-1:0] raw_err, esc_vld, resp_vld;
  logic [N_CH-1:0] filt_set, tout_set, flag_clr;

  logic [FiltW-1:0] filt_cnt_q [N_CH];
  logic [FiltW-1:0] filt_cnt_d [N_CH];
  logic [TmrW-1:0]  tmr_q      [N_CH];
  logic [TmrW-1:0]  tmr_d      [N_CH];
  logic [CNT_W-1:0] cnt_q      [N_CH];
  logic [CNT_W-1:0] cnt_d      [N_CH];
  ping_st_e         st_q       [N_CH];
  ping_st_e         st_d       [N_CH];

  logic [N_CH-1:0] integ_q, integ_d;
  logic [N_CH-1:0] tout_q, tout_d;
  logic [N_CH-1:0] ok_q, ok_d;
  logic [N_CH-1:0] active_q, active_d;
  logic            any_q, any_d;

  // Equal rails on either pair is a protocol violation.
  assign raw_err  = ~(esc_pi ^ esc_ni) | ~(resp_pi ^ resp_ni);
  assign esc_vld  = esc_pi & ~esc_ni;
  assign resp_vld = resp_pi & ~resp_ni;
  assign flag_clr = LockEn ? '0 : clr_i;

  // Integrity filter and escalation counter.
  always_comb begin
    filt_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      filt_cnt_d[i] = '0;
      cnt_d[i]      = cnt_q[i];
      if (raw_err[i]) begin
        filt_cnt_d[i] = (filt_cnt_q[i] != FiltMax) ? filt_cnt_q[i] + 1'b1 : filt_cnt_q[i];
      end
      filt_set[i] = raw_err[i] && (filt_cnt_d[i] == FiltMax);

      // A valid cycle coinciding with clr restarts the count at one.
      if (clr_i[i]) begin
        cnt_d[i] = esc_vld[i] ? CNT_W'(1) : '0;
      end else if (esc_vld[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Ping watchdog FSMs.
  always_comb begin
    tout_set = '0;
    ok_d     = '0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      unique case (st_q[i])
        StIdle: begin
          if (ping_req_i[i]) begin
            st_d[i]  = StWait;
            tmr_d[i] = '0;
          end
        end
        StWait: begin
          if (resp_vld[i] && !raw_err[i]) begin
            ok_d[i] = 1'b1;
            st_d[i] = StIdle;
          end else if (raw_err[i]) begin
            // Reported through the integrity filter, not as a ping result.
            st_d[i] = StIdle;
          end else if (tmr_q[i] == TmrMax) begin
            tout_set[i] = 1'b1;
            st_d[i]     = StTout;
          end else begin
            tmr_d[i] = tmr_q[i] + 1'b1;
          end
        end
        StTout: begin
          if (flag_clr[i]) begin
            st_d[i] = StIdle;
          end
        end
        default: st_d[i] = StIdle;
      endcase
    end
  end

  // Sticky flags: a set event beats a same-cycle clear.
  always_comb begin
    integ_d  = filt_set | (integ_q & ~flag_clr);
    tout_d   = tout_set | (tout_q & ~flag_clr);
    active_d = esc_vld;
    any_d    = |(integ_d | tout_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        filt_cnt_q[i] <= '0;
        tmr_q[i]      <= '0;
        cnt_q[i]      <= '0;
        st_q[i]       <= StIdle;
      end
      integ_q  <= '0;
      tout_q   <= '0;
      ok_q     <= '0;
      active_q <= '0;
      any_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        filt_cnt_q[i] <= filt_cnt_d[i];
        tmr_q[i]      <= tmr_d[i];
        cnt_q[i]      <= cnt_d[i];
        st_q[i]       <= st_d[i];
      end
      integ_q  <= integ_d;
      tout_q   <= tout_d;
      ok_q     <= ok_d;
      active_q <= active_d;
      any_q    <= any_d;
    end
  end

  assign integ_fail_o   = integ_q;
  assign ping_timeout_o = tout_q;
  assign ping_ok_o      = ok_q;
  assign esc_active_o   = active_q;
  assign any_fail_o     = any_q;

  always_comb begin
    esc_cnt_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      esc_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule
